// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Registered ALU that sits between operand fetch and writeback.
//   - Single-cycle ops (AND/OR/NOR/XOR/ADD/SUB/SLT/SLTU) produce a result one
//     cycle after accept.
//   - MUL, DIVU and REMU iterate one bit per BUSY cycle for WORD_LEN cycles.
//
// Handshake (both sides): a transfer happens on a rising edge where
//   valid && ready are both high. The producer keeps valid (and data)
//   asserted until that edge. in_ready is high only in IDLE. out_valid is
//   high only in DONE, and res/flags stay stable until the result transfers.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   issue handshake
//   a, b, op              operands and op code (latched on accept)
//   out_valid / out_ready result handshake
//   res                   result
//   zero                  res == 0
//   overflow              op-dependent overflow flag
//   div_zero              DIVU/REMU issued with b == 0
//   dbg_state             current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module alu_multicycle #(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_LEN-1:0] a,
  input  logic [WORD_LEN-1:0] b,
  input  logic [3:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] res,
  output logic                zero,
  output logic                overflow,
  output logic                div_zero,
  output logic [1:0]          dbg_state
);

  localparam int W  = WORD_LEN;
  localparam int CW = $clog2(WORD_LEN);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [3:0]    op_q;
  logic [W-1:0]  hi_q;    // MUL: running high half; DIV: partial remainder
  logic [W-1:0]  lo_q;    // MUL: multiplier/low half; DIV: dividend/quotient
  logic [W-1:0]  b_q;     // multiplicand / divisor
  logic [CW-1:0] cnt_q;   // iterations left after the current one
  logic [W-1:0]  res_q;
  logic          zero_q;
  logic          ovf_q;
  logic          dz_q;

  // Single-cycle result, computed straight from the accepted operands.
  logic [W-1:0] sc_res_d;
  logic         sc_ovf_d;
  logic [W-1:0] sum_w;
  logic [W-1:0] diff_w;

  always_comb begin
    sum_w    = a + b;
    diff_w   = a - b;
    sc_res_d = '0;
    sc_ovf_d = 1'b0;
    case (op)
      OP_AND:  sc_res_d = a & b;
      OP_OR:   sc_res_d = a | b;
      OP_NOR:  sc_res_d = ~(a | b);
      OP_XOR:  sc_res_d = a ^ b;
      OP_ADD: begin
        sc_res_d = sum_w;
        sc_ovf_d = (a[W-1] == b[W-1]) && (sum_w[W-1] != a[W-1]);
      end
      OP_SUB: begin
        sc_res_d = diff_w;
        sc_ovf_d = (a[W-1] != b[W-1]) && (diff_w[W-1] != a[W-1]);
      end
      // Signed compare directly, so the result is right even when a-b overflows.
      OP_SLT:  sc_res_d = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res_d = {{(W-1){1'b0}}, (a < b)};
      default: begin
        sc_res_d = '0;
        sc_ovf_d = 1'b0;
      end
    endcase
  end

  // One iteration step for MUL (shift-add) and DIVU/REMU (restoring).
  logic [W:0]   mul_sum_w;
  logic [W-1:0] mul_hi_d;
  logic [W-1:0] mul_lo_d;
  logic [W:0]   div_shift_w;
  logic [W:0]   div_trial_w;
  logic         div_ge_w;
  logic [W-1:0] div_hi_d;
  logic [W-1:0] div_lo_d;

  always_comb begin
    mul_sum_w   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    mul_hi_d    = mul_sum_w[W:1];
    mul_lo_d    = {mul_sum_w[0], lo_q[W-1:1]};
    div_shift_w = {hi_q, lo_q[W-1]};
    div_trial_w = div_shift_w - {1'b0, b_q};
    div_ge_w    = (div_shift_w >= {1'b0, b_q});
    div_hi_d    = div_ge_w ? div_trial_w[W-1:0] : div_shift_w[W-1:0];
    div_lo_d    = {lo_q[W-2:0], div_ge_w};
  end

  // Final iterative result. With b == 0 the restoring step always "fits",
  // so the quotient comes out all ones and the remainder ends up equal to a,
  // which is exactly the required divide-by-zero behaviour.
  logic [W-1:0] it_res_d;
  logic         it_ovf_d;
  logic         it_dz_d;

  always_comb begin
    it_res_d = '0;
    it_ovf_d = 1'b0;
    it_dz_d  = 1'b0;
    case (op_q)
      OP_MUL: begin
        it_res_d = mul_lo_d;
        it_ovf_d = |mul_hi_d;
      end
      OP_DIVU: begin
        it_res_d = div_lo_d;
        it_dz_d  = (b_q == '0);
      end
      OP_REMU: begin
        it_res_d = div_hi_d;
        it_dz_d  = (b_q == '0);
      end
      default: it_res_d = '0;
    endcase
  end

  logic is_iter_w;
  assign is_iter_w = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= op;
            b_q  <= b;
            hi_q <= '0;
            lo_q <= a;
            if (is_iter_w) begin
              cnt_q   <= CW'(W - 1);
              state_q <= S_BUSY;
            end else begin
              res_q   <= sc_res_d;
              zero_q  <= (sc_res_d == '0);
              ovf_q   <= sc_ovf_d;
              dz_q    <= 1'b0;
              state_q <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          if (op_q == OP_MUL) begin
            hi_q <= mul_hi_d;
            lo_q <= mul_lo_d;
          end else begin
            hi_q <= div_hi_d;
            lo_q <= div_lo_d;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            res_q   <= it_res_d;
            zero_q  <= (it_res_d == '0);
            ovf_q   <= it_ovf_d;
            dz_q    <= it_dz_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         zero, overflow, div_zero;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_multicycle #(.WORD_LEN(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .zero(zero), .overflow(overflow), .div_zero(div_zero),
    .dbg_state(dbg_state)
  );

  // ---------------- driver ----------------
  // Issue one op and wait (bounded) for its result; out_ready is 1 so the
  // result transfers on the edge after it is sampled here.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [W-1:0] r, output logic z, output logic ov,
                        output logic dz, output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = av; b = bv;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready got %b exp 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    // Operands are free to change after accept.
    in_valid = 1'b0;
    a  = W'($urandom_range(0, 255));
    b  = W'($urandom_range(0, 255));
    op = 4'($urandom_range(0, 15));
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    r = res; z = zero; ov = overflow; dz = div_zero;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, res, zero, overflow, div_zero} !== {1'b0, 8'h00, 3'b000}) begin
      bad++;
      $display("FAIL reset_outputs got ov=%b res=%h z=%b o=%b dz=%b exp all 0",
               out_valid, res, zero, overflow, div_zero);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_logic();
    logic [W-1:0] r; logic z, ov, dz; int lat;
    logic [3:0]   ops [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b1100};
    logic [W-1:0] exps[4] = '{8'h48, 8'hDE, 8'h96, 8'h21};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 8'hCA, 8'h5C, r, z, ov, dz, lat);
      total++;
      if (r !== exps[i] || ov !== 1'b0 || dz !== 1'b0 || lat != 1) begin
        bad++;
        $display("FAIL logic_op%0d got res=%h ovf=%b dz=%b lat=%0d exp res=%h ovf=0 dz=0 lat=1",
                 i, r, ov, dz, lat, exps[i]);
      end
    end
  endtask

  task automatic test_add_sub();
    logic [W-1:0] r; logic z, ov, dz; int lat;
    run_op(4'b0010, 8'h7F, 8'h01, r, z, ov, dz, lat);
    total++;
    if (r !== 8'h80 || ov !== 1'b1 || z !== 1'b0 || lat != 1) begin
      bad++; $display("FAIL add_ovf got res=%h ovf=%b z=%b lat=%0d exp 80 1 0 1", r, ov, z, lat);
    end
    run_op(4'b0010, 8'hFF, 8'h01, r, z, ov, dz, lat);
    total++;
    if (r !== 8'h00 || ov !== 1'b0 || z !== 1'b1) begin
      bad++; $display("FAIL add_wrap got res=%h ovf=%b z=%b exp 00 0 1", r, ov, z);
    end
    run_op(4'b0110, 8'h80, 8'h01, r, z, ov, dz, lat);
    total++;
    if (r !== 8'h7F || ov !== 1'b1 || z !== 1'b0) begin
      bad++; $display("FAIL sub_ovf got res=%h ovf=%b z=%b exp 7f 1 0", r, ov, z);
    end
    run_op(4'b0110, 8'h05, 8'h05, r, z, ov, dz, lat);
    total++;
    if (r !== 8'h00 || ov !== 1'b0 || z !== 1'b1) begin
      bad++; $display("FAIL sub_zero got res=%h ovf=%b z=%b exp 00 0 1", r, ov, z);
    end
  endtask

  task automatic test_compare();
    logic [W-1:0] r; logic z, ov, dz; int lat;
    logic [3:0]   ops [5] = '{4'b0111, 4'b0111, 4'b0111, 4'b1101, 4'b1101};
    logic [W-1:0] av  [5] = '{8'h80, 8'h01, 8'h7F, 8'h80, 8'h01};
    logic [W-1:0] bv  [5] = '{8'h01, 8'h80, 8'h80, 8'h01, 8'h80};
    logic [W-1:0] exps[5] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], av[i], bv[i], r, z, ov, dz, lat);
      total++;
      if (r !== exps[i] || ov !== 1'b0 || z !== (exps[i] == 8'h00)) begin
        bad++;
        $display("FAIL cmp%0d got res=%h ovf=%b z=%b exp res=%h ovf=0", i, r, ov, z, exps[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] r; logic z, ov, dz; int lat;
    run_op(4'b1000, 8'h0F, 8'h11, r, z, ov, dz, lat);
    total++;
    if (r !== 8'hFF || ov !== 1'b0 || z !== 1'b0 || lat != 9) begin
      bad++; $display("FAIL mul_ff got res=%h ovf=%b z=%b lat=%0d exp ff 0 0 9", r, ov, z, lat);
    end
    run_op(4'b1000, 8'h10, 8'h10, r, z, ov, dz, lat);
    total++;
    if (r !== 8'h00 || ov !== 1'b1 || z !== 1'b1 || dz !== 1'b0) begin
      bad++; $display("FAIL mul_ovf got res=%h ovf=%b z=%b dz=%b exp 00 1 1 0", r, ov, z, dz);
    end
    run_op(4'b1000, 8'hFF, 8'hFF, r, z, ov, dz, lat);
    total++;
    if (r !== 8'h01 || ov !== 1'b1) begin
      bad++; $display("FAIL mul_max got res=%h ovf=%b exp 01 1", r, ov);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] r; logic z, ov, dz; int lat;
    logic [3:0]   ops [6] = '{4'b1001, 4'b1010, 4'b1001, 4'b1010, 4'b1001, 4'b1001};
    logic [W-1:0] av  [6] = '{8'd100, 8'd100, 8'd5, 8'd5, 8'd7, 8'd255};
    logic [W-1:0] bv  [6] = '{8'd7, 8'd7, 8'd0, 8'd0, 8'd100, 8'd16};
    logic [W-1:0] exps[6] = '{8'd14, 8'd2, 8'hFF, 8'd5, 8'd0, 8'd15};
    logic         dzs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], av[i], bv[i], r, z, ov, dz, lat);
      total++;
      if (r !== exps[i] || dz !== dzs[i] || ov !== 1'b0 || z !== (exps[i] == 8'h00) || lat != 9) begin
        bad++;
        $display("FAIL div%0d got res=%h dz=%b ovf=%b z=%b lat=%0d exp res=%h dz=%b lat=9",
                 i, r, dz, ov, z, lat, exps[i], dzs[i]);
      end
    end
  endtask

  task automatic test_invalid_op();
    logic [W-1:0] r; logic z, ov, dz; int lat;
    run_op(4'b0100, 8'hAA, 8'h55, r, z, ov, dz, lat);
    total++;
    if (r !== 8'h00 || ov !== 1'b0 || dz !== 1'b0 || z !== 1'b1 || lat != 1) begin
      bad++; $display("FAIL bad_op got res=%h ovf=%b dz=%b z=%b lat=%0d exp 00 0 0 1 1", r, ov, dz, z, lat);
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = 4'b0010; a = 8'h03; b = 8'h04;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || res !== 8'h07 || zero !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got ov=%b res=%h z=%b o=%b ir=%b exp 1 07 0 0 0",
                 i, out_valid, res, zero, overflow, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got ov=%b ir=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_busy();
    logic [W-1:0] r; logic z, ov, dz; int lat; int seen;
    @(negedge clk);
    in_valid = 1'b1; op = 4'b1000; a = 8'h0F; b = 8'h11;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL rst_busy got ov=%b ir=%b st=%0d exp 0 1 0", out_valid, in_ready, dbg_state);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rst_busy_emit got %0d valid cycles exp 0", seen); end
    run_op(4'b0010, 8'h01, 8'h02, r, z, ov, dz, lat);
    total++;
    if (r !== 8'h03 || ov !== 1'b0 || z !== 1'b0 || lat != 1) begin
      bad++; $display("FAIL rst_busy_add got res=%h ovf=%b z=%b lat=%0d exp 03 0 0 1", r, ov, z, lat);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_logic();
    test_add_sub();
    test_compare();
    test_mul();
    test_div();
    test_invalid_op();
    test_backpressure();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
